// File: rtl/multi_sync_filter.sv
// Per-channel multi-flop synchronizer with a stability filter and registered
// rise/fall pulses. Every output is driven from a flop; nothing is combinational from DataIn.
module multi_sync_filter #(
  parameter int               WIDTH         = 8,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataOut,
  output logic [WIDTH-1:0] RiseOut,
  output logic [WIDTH-1:0] FallOut
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("multi_sync_filter: WIDTH must be in 1..32");
  end
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("multi_sync_filter: STAGES must be in 2..4");
  end
  if (FILTER_CYCLES < 0 || FILTER_CYCLES > 255) begin : g_bad_filter
    $error("multi_sync_filter: FILTER_CYCLES must be in 0..255");
  end

  logic [WIDTH-1:0] sync_p [STAGES];
  logic [WIDTH-1:0] out_next;

  // Synchronizer chain: sync_p[STAGES-1] is the synchronized value
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_p[s] <= RST_VAL;
      end
    end else begin
      sync_p[0] <= DataIn;
      for (int s = 1; s < STAGES; s++) begin
        sync_p[s] <= sync_p[s-1];
      end
    end
  end

  if (FILTER_CYCLES == 0) begin : g_bypass
    // The value the last flop takes on the next edge drives the pulse registers
    assign out_next = sync_p[STAGES-2];
    assign DataOut  = sync_p[STAGES-1];
  end else begin : g_filter
    localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_p    [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] out_p;

    // Per-channel stability count; the output follows only after a full run
    always_comb begin
      out_next = out_p;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_next[i] = '0;
        if (sync_p[STAGES-1][i] != out_p[i]) begin
          if (cnt_p[i] == CNT_LAST) begin
            out_next[i] = sync_p[STAGES-1][i];
          end else begin
            cnt_next[i] = cnt_p[i] + CNT_W'(1);
          end
        end
      end
    end

    // Filter stage
    always_ff @(posedge Clock) begin
      if (Reset) begin
        out_p <= RST_VAL;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_p[i] <= '0;
        end
      end else begin
        out_p <= out_next;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_p[i] <= cnt_next[i];
        end
      end
    end

    assign DataOut = out_p;
  end

  // Edge pulse stage: registered alongside the DataOut update
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RiseOut <= '0;
      FallOut <= '0;
    end else begin
      RiseOut <= out_next & ~DataOut;
      FallOut <= ~out_next & DataOut;
    end
  end

endmodule

// File: tb/tb_multi_sync_filter.sv
// Bench for multi_sync_filter: directed vector table, hand-built corner sequences,
// then random stimulus against a delay-line/run-length reference model.
module tb_multi_sync_filter;

  localparam logic [7:0] RST = 8'h0F;
  localparam int         FC  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_a, din_b;
  logic [7:0] a_out, a_rise, a_fall;
  logic [7:0] b_out, b_rise, b_fall;

  always #5 clk = ~clk;

  multi_sync_filter #(.WIDTH(8), .STAGES(2), .FILTER_CYCLES(4), .RST_VAL(RST)) dut_a (
    .Clock(clk), .Reset(rst), .DataIn(din_a),
    .DataOut(a_out), .RiseOut(a_rise), .FallOut(a_fall)
  );

  multi_sync_filter #(.WIDTH(8), .STAGES(3), .FILTER_CYCLES(0), .RST_VAL(RST)) dut_b (
    .Clock(clk), .Reset(rst), .DataIn(din_b),
    .DataOut(b_out), .RiseOut(b_rise), .FallOut(b_fall)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: input delay line of STAGES samples, then a run-length
  // filter that flips a channel once it has disagreed for FC consecutive edges.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] ma_out, ma_rise, ma_fall;
  logic [7:0] mb_out, mb_rise, mb_fall;
  int         ma_run [8];

  always @(posedge clk) begin : model
    logic [7:0] s, nxt, old;
    if (rst) begin
      qa.delete();
      qb.delete();
      repeat (2) qa.push_back(RST);
      repeat (3) qb.push_back(RST);
      ma_out = RST; ma_rise = 8'h00; ma_fall = 8'h00;
      mb_out = RST; mb_rise = 8'h00; mb_fall = 8'h00;
      for (int i = 0; i < 8; i++) ma_run[i] = 0;
    end else begin
      s   = qa[0];
      nxt = ma_out;
      for (int i = 0; i < 8; i++) begin
        if (s[i] == ma_out[i]) begin
          ma_run[i] = 0;
        end else begin
          ma_run[i] = ma_run[i] + 1;
          if (ma_run[i] == FC) begin
            nxt[i]    = s[i];
            ma_run[i] = 0;
          end
        end
      end
      ma_rise = nxt & ~ma_out;
      ma_fall = ~nxt & ma_out;
      ma_out  = nxt;
      void'(qa.pop_front());
      qa.push_back(din_a);

      old = mb_out;
      void'(qb.pop_front());
      qb.push_back(din_b);
      mb_out  = qb[0];
      mb_rise = mb_out & ~old;
      mb_fall = ~mb_out & old;
    end
  end

  typedef struct {
    logic       rst;
    logic [7:0] din;
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int n, input logic r, input logic [7:0] d,
                              input logic [7:0] o, input logic [7:0] ri, input logic [7:0] fa);
    vec_t v;
    v = '{r, d, o, ri, fa};
    repeat (n) tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] mask;
    rst   = 1'b1;
    din_a = 8'hF0;
    din_b = 8'h00;

    // Reset with DataIn=F0, then F0 propagates on edge 6 after release
    add(3, 1'b1, 8'hF0, 8'h0F, 8'h00, 8'h00);
    add(5, 1'b0, 8'hF0, 8'h0F, 8'h00, 8'h00);
    add(1, 1'b0, 8'hF0, 8'hF0, 8'hF0, 8'h0F);
    add(1, 1'b0, 8'hF0, 8'hF0, 8'h00, 8'h00);
    // Drive everything low to reach DataOut=00
    add(5, 1'b0, 8'h00, 8'hF0, 8'h00, 8'h00);
    add(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'hF0);
    add(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    // 3-cycle glitch on bit 0 is rejected
    add(3, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00);
    add(4, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    // 4-cycle pulse on bit 0 passes, then the return to 0 passes too
    add(4, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00);
    add(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 1'b0, 8'h00, 8'h01, 8'h01, 8'h00);
    add(3, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00);
    add(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01);
    add(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int k = 0; k < tbl.size(); k++) begin
      rst   = tbl[k].rst;
      din_a = tbl[k].din;
      step();
      chk($sformatf("tbl%0d_out", k),  a_out,  tbl[k].out);
      chk($sformatf("tbl%0d_rise", k), a_rise, tbl[k].rise);
      chk($sformatf("tbl%0d_fall", k), a_fall, tbl[k].fall);
    end

    // Reset in the middle of a count; count restarts after release
    din_a = 8'h01;
    rst   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("s4_pre%0d_out", k), a_out, 8'h00);
    end
    rst = 1'b1;
    step();
    chk("s4_rst_out",  a_out,  RST);
    chk("s4_rst_rise", a_rise, 8'h00);
    chk("s4_rst_fall", a_fall, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("s4_post%0d_out", k),  a_out,  (k == 5) ? 8'h01 : RST);
      chk($sformatf("s4_post%0d_rise", k), a_rise, 8'h00);
      chk($sformatf("s4_post%0d_fall", k), a_fall, (k == 5) ? 8'h0E : 8'h00);
    end
    step();
    chk("s4_after_out",  a_out,  8'h01);
    chk("s4_after_fall", a_fall, 8'h00);

    // Bit 7 chatters every 2 cycles while bit 1 steps high
    for (int k = 0; k < 16; k++) begin
      din_a = 8'h03 | ((k < 12 && ((k >> 1) & 1) == 0) ? 8'h80 : 8'h00);
      step();
      chk($sformatf("s5_%0d_out", k),  a_out,  (k >= 5) ? 8'h03 : 8'h01);
      chk($sformatf("s5_%0d_rise", k), a_rise, (k == 5) ? 8'h02 : 8'h00);
      chk($sformatf("s5_%0d_fall", k), a_fall, 8'h00);
    end

    // Bypass instance: 3-flop latency, single-cycle rise pulse
    din_b = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("s6_%0d_out", k),  b_out,  (k >= 2) ? 8'hFF : 8'h00);
      chk($sformatf("s6_%0d_rise", k), b_rise, (k == 2) ? 8'hFF : 8'h00);
      chk($sformatf("s6_%0d_fall", k), b_fall, 8'h00);
    end

    // Random stimulus against the reference model
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 49) == 0);
      mask = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 4) == 0) mask[b] = 1'b1;
      end
      din_a = din_a ^ mask;
      if ($urandom_range(0, 1) == 1) din_b = 8'($urandom);
      step();
      chk("rnd_a_out",  a_out,  ma_out);
      chk("rnd_a_rise", a_rise, ma_rise);
      chk("rnd_a_fall", a_fall, ma_fall);
      chk("rnd_a_excl", a_rise & a_fall, 8'h00);
      chk("rnd_b_out",  b_out,  mb_out);
      chk("rnd_b_rise", b_rise, mb_rise);
      chk("rnd_b_fall", b_fall, mb_fall);
      chk("rnd_b_excl", b_rise & b_fall, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
